// File: rtl/heater_relay_sequencer_pkg.sv
// heater_relay_sequencer_pkg: state encoding, sensor width and default dwell lengths
package heater_relay_sequencer_pkg;
  localparam int window_sensor_data_width = 4;
  localparam int purge_cycles_default = 4;
  localparam int min_on_cycles_default = 16;
  localparam int min_off_cycles_default = 16;
  localparam int max_on_cycles_default = 1024;
  localparam int cnt_width_default = 16;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PURGE    = 3'd1,
    HEAT     = 3'd2,
    COOLDOWN = 3'd3,
    FAULT    = 3'd4
  } state_e;
endpackage

// File: rtl/heater_dwell_counter.sv
// heater_dwell_counter: saturating dwell counter with sync clear and enable
module heater_dwell_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : (en && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/heater_relay_sequencer.sv
// heater_relay_sequencer: purge, min-on, min-off and max-on sequencing of heater relay and fan
module heater_relay_sequencer
  import heater_relay_sequencer_pkg::*;
#(
  parameter int PURGE_CYCLES   = purge_cycles_default,
  parameter int MIN_ON_CYCLES  = min_on_cycles_default,
  parameter int MIN_OFF_CYCLES = min_off_cycles_default,
  parameter int MAX_ON_CYCLES  = max_on_cycles_default,
  parameter int CNT_WIDTH      = cnt_width_default
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                heat_req,
  input  logic [window_sensor_data_width-1:0] window_open,
  input  logic                                fault_clear,
  output logic                                fan_on,
  output logic                                relay_on,
  output logic                                lockout,
  output logic                                fault,
  output logic [2:0]                          state
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic win;
  assign win = |window_open;
  heater_dwell_counter #(.CNT_WIDTH(CNT_WIDTH)) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (state_d != state_q),
    .en   (1'b1),
    .cnt  (cnt)
  );
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:     state_d = (heat_req && !win) ? PURGE : IDLE;
      PURGE:    state_d = (!heat_req || win) ? IDLE :
                          (cnt == CNT_WIDTH'(PURGE_CYCLES - 1)) ? HEAT : PURGE;
      HEAT:     state_d = win ? COOLDOWN :
                          (cnt == CNT_WIDTH'(MAX_ON_CYCLES - 1)) ? FAULT :
                          (!heat_req && cnt >= CNT_WIDTH'(MIN_ON_CYCLES - 1)) ? COOLDOWN : HEAT;
      COOLDOWN: state_d = (cnt == CNT_WIDTH'(MIN_OFF_CYCLES - 1)) ? IDLE : COOLDOWN;
      FAULT:    state_d = fault_clear ? COOLDOWN : FAULT;
      default:  state_d = IDLE;
    endcase
  end
  assign fan_on   = state_q inside {PURGE, HEAT, COOLDOWN};
  assign relay_on = state_q == HEAT;
  assign lockout  = state_q inside {COOLDOWN, FAULT};
  assign fault    = state_q == FAULT;
  assign state    = state_q;
endmodule
